// File: rtl/forward_pkg.sv
// Shared types for the operand-forwarding tracker.
// A package cannot see the parameters of the module that imports it. The tracker
// entry therefore carries a register address of MaxRegWidth bits, and the stage
// index is sized for MaxStages. A REG_WIDTH or STAGES above these limits is unsupported.
package forward_pkg;

  localparam int unsigned MaxRegWidth = 8;
  localparam int unsigned MaxStages   = 16;

  typedef logic [MaxRegWidth-1:0]       reg_addr_t;
  typedef logic [$clog2(MaxStages)-1:0] stage_idx_t;

  // Architectural zero register: never forwarded.
  localparam reg_addr_t RegZero = '0;

  typedef struct packed {
    logic      valid;
    logic      write;
    logic      is_load;
    reg_addr_t rd;
  } fwd_entry_t;

endpackage

// File: rtl/forward_match.sv
// Per-source forwarding selector.
// Compares one source address against every tracked stage. The youngest
// matching stage (lowest index) supplies the operand. Raises a hazard when
// that producer is a load whose data is not valid yet.
// Ports:
//   entries_i    tracker entries, index 0 youngest
//   rs_addr_i    source register address
//   rs_data_i    register-file read data
//   stage_data_i results held in each stage, aligned with entries_i
//   rs_data_o    forwarded operand
//   hit_o        operand taken from a stage
//   hazard_o     winning producer is a load not yet at LOAD_STAGE
module forward_match
  import forward_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  fwd_entry_t [STAGES-1:0]            entries_i,
  input  logic       [REG_WIDTH-1:0]         rs_addr_i,
  input  logic       [DATA_WIDTH-1:0]        rs_data_i,
  input  logic       [STAGES*DATA_WIDTH-1:0] stage_data_i,
  output logic       [DATA_WIDTH-1:0]        rs_data_o,
  output logic                               hit_o,
  output logic                               hazard_o
);

  reg_addr_t  addr;
  stage_idx_t sel_idx;
  logic       sel_load;

  assign addr = reg_addr_t'(rs_addr_i);

  // Scan oldest to youngest so that the last match, which is the youngest, wins.
  always_comb begin
    hit_o     = 1'b0;
    sel_idx   = '0;
    sel_load  = 1'b0;
    rs_data_o = rs_data_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (entries_i[k].valid && entries_i[k].write && (entries_i[k].rd == addr) &&
          (addr != RegZero)) begin
        hit_o     = 1'b1;
        sel_idx   = stage_idx_t'(k);
        sel_load  = entries_i[k].is_load;
        rs_data_o = stage_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign hazard_o = hit_o && sel_load && (sel_idx < stage_idx_t'(LOAD_STAGE));

endmodule

// File: rtl/forward_tracker.sv
// Operand-forwarding unit for the integer pipeline.
// Tracks the destination of each in-flight instruction from EX (stage 0) to
// WB (stage STAGES-1). Substitutes the youngest in-flight result for each
// decode source operand. Raises a load-use stall when that result is not ready.
// Optional feature macro: FORWARD_TRACKER_STATS_EN adds a saturating stall-cycle counter.
// Ports:
//   i_Clock, i_Reset           clock, synchronous active-high reset
//   i_Advance                  back-end enable; entries shift only when high
//   i_Flush                    decode instruction dropped (bubble enters stage 0)
//   i_IssueValid/Write/IsLoad  decode instruction attributes
//   i_IssueRd                  decode destination register
//   i_RsAddr, i_RsData         source addresses and register-file data (index 0 in LSBs)
//   i_StageData                per-stage results aligned with tracker entries
//   o_RsData, o_RsHit          forwarded operands and per-source hit flags
//   o_Stall                    load-use hazard; decode and fetch hold
//   o_StallCount               stall-cycle counter (stats build only)
module forward_tracker
  import forward_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned REG_WIDTH  = 5,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned SOURCES    = 2,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Advance,
  input  logic                          i_Flush,
  input  logic                          i_IssueValid,
  input  logic                          i_IssueWrite,
  input  logic                          i_IssueIsLoad,
  input  logic [REG_WIDTH-1:0]          i_IssueRd,
  input  logic [SOURCES*REG_WIDTH-1:0]  i_RsAddr,
  input  logic [SOURCES*DATA_WIDTH-1:0] i_RsData,
  input  logic [STAGES*DATA_WIDTH-1:0]  i_StageData,
  output logic [SOURCES*DATA_WIDTH-1:0] o_RsData,
  output logic [SOURCES-1:0]            o_RsHit,
  output logic                          o_Stall
`ifdef FORWARD_TRACKER_STATS_EN
  ,
  output logic [31:0]                   o_StallCount
`endif
);

  fwd_entry_t [STAGES-1:0] entries_q, entries_d;
  logic       [SOURCES-1:0] hazard;

  for (genvar s = 0; s < SOURCES; s++) begin : g_src
    forward_match #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_WIDTH  (REG_WIDTH),
      .STAGES     (STAGES),
      .LOAD_STAGE (LOAD_STAGE)
    ) u_match (
      .entries_i    (entries_q),
      .rs_addr_i    (i_RsAddr[s*REG_WIDTH +: REG_WIDTH]),
      .rs_data_i    (i_RsData[s*DATA_WIDTH +: DATA_WIDTH]),
      .stage_data_i (i_StageData),
      .rs_data_o    (o_RsData[s*DATA_WIDTH +: DATA_WIDTH]),
      .hit_o        (o_RsHit[s]),
      .hazard_o     (hazard[s])
    );
  end

  assign o_Stall = |hazard;

  // A stalled or flushed decode slot becomes a bubble. While the back end is
  // held, all entries freeze, and a pending stall persists with them.
  always_comb begin
    entries_d = entries_q;
    if (i_Advance) begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = '0;
      if (i_IssueValid && !o_Stall && !i_Flush) begin
        entries_d[0] = '{valid:   1'b1,
                         write:   i_IssueWrite,
                         is_load: i_IssueIsLoad,
                         rd:      reg_addr_t'(i_IssueRd)};
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

`ifdef FORWARD_TRACKER_STATS_EN
  logic [31:0] stall_count_q;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      stall_count_q <= '0;
    end else if (o_Stall && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign o_StallCount = stall_count_q;
`endif

endmodule

// File: tb/tb_forward_tracker.sv
module tb_forward_tracker;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int ST  = 3;
  localparam int SRC = 2;
  localparam int LS  = 1;

  logic              clk = 1'b0;
  logic              rst, adv, flush, iv, iw, il;
  logic [RW-1:0]     ird;
  logic [SRC*RW-1:0] rs_addr;
  logic [SRC*DW-1:0] rs_data;
  logic [ST*DW-1:0]  stage_data;
  logic [SRC*DW-1:0] out_data;
  logic [SRC-1:0]    out_hit;
  logic              out_stall;
`ifdef FORWARD_TRACKER_STATS_EN
  logic [31:0]       out_count;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  forward_tracker #(
    .DATA_WIDTH (DW),
    .REG_WIDTH  (RW),
    .STAGES     (ST),
    .SOURCES    (SRC),
    .LOAD_STAGE (LS)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst),
    .i_Advance     (adv),
    .i_Flush       (flush),
    .i_IssueValid  (iv),
    .i_IssueWrite  (iw),
    .i_IssueIsLoad (il),
    .i_IssueRd     (ird),
    .i_RsAddr      (rs_addr),
    .i_RsData      (rs_data),
    .i_StageData   (stage_data),
    .o_RsData      (out_data),
    .o_RsHit       (out_hit),
    .o_Stall       (out_stall)
`ifdef FORWARD_TRACKER_STATS_EN
    ,
    .o_StallCount  (out_count)
`endif
  );

  // Reference model: a list of in-flight instructions, index 0 youngest.
  bit          m_valid[ST];
  bit          m_write[ST];
  bit          m_load[ST];
  logic [RW-1:0] m_rd[ST];
  logic [31:0] m_count;

  function automatic void model_eval(output logic [SRC*DW-1:0] d, output logic [SRC-1:0] h,
                                     output logic stall);
    stall = 1'b0;
    for (int s = 0; s < SRC; s++) begin
      logic [RW-1:0] a;
      bit found;
      a = rs_addr[s*RW +: RW];
      found = 1'b0;
      d[s*DW +: DW] = rs_data[s*DW +: DW];
      h[s] = 1'b0;
      if (a != 0) begin
        for (int k = 0; k < ST; k++) begin
          if (!found && m_valid[k] && m_write[k] && m_rd[k] == a) begin
            found = 1'b1;
            d[s*DW +: DW] = stage_data[k*DW +: DW];
            h[s] = 1'b1;
            if (m_load[k] && k < LS) stall = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [SRC*DW-1:0] d;
    logic [SRC-1:0]    h;
    logic              st;
    model_eval(d, h, st);
    if (rst) begin
      for (int k = 0; k < ST; k++) begin
        m_valid[k] = 1'b0; m_write[k] = 1'b0; m_load[k] = 1'b0; m_rd[k] = '0;
      end
      m_count = 0;
    end else begin
      if (st && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
      if (adv) begin
        for (int k = ST - 1; k >= 1; k--) begin
          m_valid[k] = m_valid[k-1]; m_write[k] = m_write[k-1];
          m_load[k]  = m_load[k-1];  m_rd[k]    = m_rd[k-1];
        end
        m_valid[0] = iv && !st && !flush;
        m_write[0] = iw; m_load[0] = il; m_rd[0] = ird;
      end
    end
  end

  always @(negedge clk) begin
    logic [SRC*DW-1:0] d;
    logic [SRC-1:0]    h;
    logic              st;
    if (chk_en) begin
      model_eval(d, h, st);
      check("model_data", 64'(out_data), 64'(d));
      check("model_hit", 64'(out_hit), 64'(h));
      check("model_stall", 64'(out_stall), 64'(st));
`ifdef FORWARD_TRACKER_STATS_EN
      check("model_count", 64'(out_count), 64'(m_count));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input int s, input logic [RW-1:0] a, input logic [DW-1:0] d);
    rs_addr[s*RW +: RW] = a;
    rs_data[s*DW +: DW] = d;
  endtask

  task automatic issue(input bit v, input bit w, input bit l, input logic [RW-1:0] rd);
    iv = v; iw = w; il = l; ird = rd;
  endtask

  task automatic do_reset();
    rst = 1'b1; adv = 1'b0; flush = 1'b0;
    issue(0, 0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; adv = 1'b0; flush = 1'b0;
    issue(0, 0, 0, 0);
    rs_addr = '0; rs_data = '0; stage_data = '0;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Out of reset: register-file data passes straight through.
    set_rs(0, 5'd1, 32'h11);
    set_rs(1, 5'd2, 32'h22);
    #2;
    check("reset_data", 64'(out_data), 64'h0000_0022_0000_0011);
    check("reset_hit", 64'(out_hit), 64'd0);
    check("reset_stall", 64'(out_stall), 64'd0);
`ifdef FORWARD_TRACKER_STATS_EN
    check("reset_count", 64'(out_count), 64'd0);
`endif

    // ALU write to x5 forwarded from stage 0.
    issue(1, 1, 0, 5'd5); adv = 1'b1;
    tick();
    issue(0, 0, 0, 0); adv = 1'b0;
    stage_data[0 +: DW] = 32'hAAAA;
    set_rs(1, 5'd5, 32'h22);
    #2;
    check("alu_fwd_data", 64'(out_data[DW +: DW]), 64'hAAAA);
    check("alu_fwd_hit", 64'(out_hit), 64'b10);

    // x5 at stage 2 and stage 0: the youngest wins.
    adv = 1'b1;
    tick();
    issue(1, 1, 0, 5'd5);
    tick();
    issue(0, 0, 0, 0); adv = 1'b0;
    stage_data = {32'h2222, 32'h1111, 32'h0000};
    #2;
    check("youngest_data", 64'(out_data[DW +: DW]), 64'h0);
    check("youngest_hit", 64'(out_hit[1]), 64'd1);

    // A tracked write to x0 is never forwarded.
    issue(1, 1, 0, 5'd0); adv = 1'b1;
    tick();
    issue(0, 0, 0, 0); adv = 1'b0;
    set_rs(0, 5'd0, 32'h55);
    #2;
    check("x0_data", 64'(out_data[0 +: DW]), 64'h55);
    check("x0_hit", 64'(out_hit[0]), 64'd0);

    // Load-use with LOAD_STAGE=1: one stall cycle, bubble replaces the x9 issue.
    do_reset();
    issue(1, 1, 1, 5'd7); adv = 1'b1;
    tick();
    issue(1, 1, 0, 5'd9);
    set_rs(0, 5'd7, 32'h77);
    set_rs(1, 5'd9, 32'h99);
    stage_data = {32'h333, 32'h222, 32'h111};
    #2;
    check("load_stall_on", 64'(out_stall), 64'd1);
    check("load_stall_hit", 64'(out_hit[0]), 64'd1);
    tick();
    issue(0, 0, 0, 0);
    #2;
    check("load_stall_off", 64'(out_stall), 64'd0);
    check("load_fwd_data", 64'(out_data[0 +: DW]), 64'h222);
    check("load_bubble_hit", 64'(out_hit), 64'b01);

    // Holding the back end extends the stall: 3 held cycles + 1 advancing.
    do_reset();
    issue(1, 1, 1, 5'd7); adv = 1'b1;
    tick();
    issue(0, 0, 0, 0); adv = 1'b0;
    set_rs(0, 5'd7, 32'h77);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) adv = 1'b1;
      #2;
      check("hold_stall_on", 64'(out_stall), 64'd1);
      tick();
    end
    adv = 1'b0;
    #2;
    check("hold_stall_off", 64'(out_stall), 64'd0);
`ifdef FORWARD_TRACKER_STATS_EN
    check("hold_stall_count", 64'(out_count), 64'd4);
`endif

    // Flushed issue never becomes visible.
    do_reset();
    issue(1, 1, 0, 5'd9); flush = 1'b1; adv = 1'b1;
    tick();
    issue(0, 0, 0, 0); flush = 1'b0; adv = 1'b0;
    set_rs(1, 5'd9, 32'h99);
    #2;
    check("flush_hit", 64'(out_hit[1]), 64'd0);

    // Reset during a stall clears it on the next cycle.
    issue(1, 1, 1, 5'd7); adv = 1'b1;
    tick();
    issue(0, 0, 0, 0); adv = 1'b0;
    set_rs(0, 5'd7, 32'h77);
    #2;
    check("rst_mid_stall_on", 64'(out_stall), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("rst_mid_stall_off", 64'(out_stall), 64'd0);
    check("rst_mid_hit", 64'(out_hit), 64'd0);
    check("rst_mid_data", 64'(out_data[0 +: DW]), 64'h77);

    // Randomized traffic over a small register range to provoke matches.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      rst   = ($urandom_range(0, 63) == 0);
      adv   = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
            $urandom_range(0, 2) == 0, RW'($urandom_range(0, 7)));
      for (int s = 0; s < SRC; s++) begin
        set_rs(s, RW'($urandom_range(0, 7)), $urandom);
      end
      for (int k = 0; k < ST; k++) begin
        stage_data[k*DW +: DW] = $urandom;
      end
    end
    @(posedge clk);
    #1;
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
